layer_output_writer: RTL and testbench

//  Write-side counterpart of the BRAM weight loaders: captures a flat
//  NUM_WORDS*W-bit layer result vector on start and streams it into the

---
 rtl/layer_output_writer.sv | 195 +++++++++++++++++++
 tb/tb_layer_output_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_writer.sv
// Layer output writer: snapshots a flat result vector and streams it into BRAM,
// then optionally reads the region back and counts mismatching words.
module layer_output_writer #(
    parameter int NUM_WORDS  = 8,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int BASE_ADDR  = 12288,
    parameter int RD_LAT     = 2,
    parameter int VERIFY     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_WORDS*W-1:0] data_in,
    output logic                   bram_en,
    output logic                   bram_wen,
    output logic                   bram_ren,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [W-1:0]           bram_din,
    input  logic [W-1:0]           bram_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   verify_err,
    output logic [ADDR_WIDTH:0]    err_count
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PL = (RD_LAT > 0) ? RD_LAT : 1;
    localparam int DW = (PL > 1) ? $clog2(PL) : 1;
    localparam int EW = ADDR_WIDTH + 1;

    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [DW-1:0]         LAST_DRN = DW'(PL - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [EW-1:0]         ERR_MAX  = EW'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DW-1:0]          drn, drn_n;
    logic [NUM_WORDS*W-1:0] snap;
    logic                   load;
    logic                   en_n, wen_n, ren_n, busy_n, done_n;
    logic [W-1:0]           din_n;
    logic [PL-1:0]          pv;
    logic [IW-1:0]          pidx [PL];
    logic                   hit;
    logic [EW-1:0]          err_n;

    // State register plus word/drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            drn   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            drn   <= drn_n;
        end
    end

    // Next state and next (to-be-registered) BRAM/status outputs
    always_comb begin
        state_n = state;
        idx_n   = idx;
        drn_n   = drn;
        load    = 1'b0;
        en_n    = 1'b0;
        wen_n   = 1'b0;
        ren_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        din_n   = '0;
        unique case (state)
            S_IDLE, S_DONE: begin
                done_n = (state == S_DONE);
                if (start) begin
                    load    = 1'b1;
                    state_n = S_WRITE;
                    idx_n   = '0;
                    en_n    = 1'b1;
                    wen_n   = 1'b1;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    din_n   = data_in[W-1:0];
                end
            end
            S_WRITE: begin
                if (idx == LAST_IDX) begin
                    if (VERIFY != 0) begin
                        state_n = S_VERIFY;
                        idx_n   = '0;
                        en_n    = 1'b1;
                        ren_n   = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    idx_n  = idx + 1'b1;
                    en_n   = 1'b1;
                    wen_n  = 1'b1;
                    busy_n = 1'b1;
                    din_n  = snap[int'(idx_n)*W +: W];
                end
            end
            S_VERIFY: begin
                en_n   = 1'b1;
                busy_n = 1'b1;
                if (idx == LAST_IDX) begin
                    state_n = S_DRAIN;
                    drn_n   = '0;
                end else begin
                    idx_n = idx + 1'b1;
                    ren_n = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn == LAST_DRN) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    drn_n  = drn + 1'b1;
                    en_n   = 1'b1;
                    busy_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Compare the read returning now against the word it was issued for
    always_comb begin
        hit   = pv[PL-1] && (bram_dout != snap[int'(pidx[PL-1])*W +: W]);
        err_n = err_count;
        if (load)
            err_n = '0;
        else if (hit && err_count != ERR_MAX)
            err_n = err_count + 1'b1;
    end

    // Registered outputs, snapshot and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_en    <= 1'b0;
            bram_wen   <= 1'b0;
            bram_ren   <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_err <= 1'b0;
            err_count  <= '0;
            snap       <= '0;
        end else begin
            bram_en    <= en_n;
            bram_wen   <= wen_n;
            bram_ren   <= ren_n;
            bram_addr  <= BASE + ADDR_WIDTH'(idx_n);
            bram_din   <= din_n;
            busy       <= busy_n;
            done       <= done_n;
            verify_err <= (state_n == S_DONE) && (err_n != '0);
            err_count  <= err_n;
            if (load)
                snap <= data_in;
        end
    end

    // Per-issue valid/index pipeline matching the BRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < PL; i++)
                pidx[i] <= '0;
        end else begin
            pv[0]   <= bram_ren;
            pidx[0] <= idx;
            for (int i = 1; i < PL; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

endmodule

// File: tb/tb_layer_output_writer.sv
// Bench for layer_output_writer: randomized transfers, BRAM models, and a
// scoreboard of expected bus operations and completion results.
module tb_layer_output_writer;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 15;
    localparam int RL = 2;
    localparam int B1 = 32765;
    localparam int B0 = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N*W-1:0]   data_in = '0;

    logic             en1, wen1, ren1, busy1, done1, verr1;
    logic [AW-1:0]    addr1;
    logic [W-1:0]     din1;
    logic [W-1:0]     dout1;
    logic [AW:0]      errc1;

    logic             en0, wen0, ren0, busy0, done0, verr0;
    logic [AW-1:0]    addr0;
    logic [W-1:0]     din0;
    logic [AW:0]      errc0;
    logic [W-1:0]     dout0 = '0;

    layer_output_writer #(
        .NUM_WORDS(N), .W(W), .ADDR_WIDTH(AW),
        .BASE_ADDR(B1), .RD_LAT(RL), .VERIFY(1)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .bram_en(en1), .bram_wen(wen1), .bram_ren(ren1),
        .bram_addr(addr1), .bram_din(din1), .bram_dout(dout1),
        .busy(busy1), .done(done1), .verify_err(verr1), .err_count(errc1)
    );

    layer_output_writer #(
        .NUM_WORDS(N), .W(W), .ADDR_WIDTH(AW),
        .BASE_ADDR(B0), .RD_LAT(RL), .VERIFY(0)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .bram_en(en0), .bram_wen(wen0), .bram_ren(ren0),
        .bram_addr(addr0), .bram_din(din0), .bram_dout(dout0),
        .busy(busy0), .done(done0), .verify_err(verr0), .err_count(errc0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // BRAM models: u1 gets a read path with optional forced-0xFF corruption
    logic [W-1:0] mem1 [0:32767];
    logic [W-1:0] mem0 [0:32767];
    logic [W-1:0] p0 = '0;
    logic [N-1:0] bad_mask = '0;

    always @(posedge clk) begin
        if (en1 && wen1) mem1[addr1] <= din1;
        if (en1 && ren1)
            p0 <= bad_mask[3'(addr1 - 15'(B1))] ? 8'hFF : mem1[addr1];
        else
            p0 <= '0;
        dout1 <= p0;
        if (en0 && wen0) mem0[addr0] <= din0;
    end

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } op_t;

    typedef struct {
        int            t_done;
        logic [AW:0]   err;
        logic [N*W-1:0] words;
    } res_t;

    op_t  opq[$];
    res_t rq1[$];
    res_t rq0[$];

    // Reference model: expected bus ops and completion for one transfer
    task automatic issue(input logic [N*W-1:0] d, input logic [N-1:0] mask);
        op_t  o;
        res_t r;
        int   e = 0;
        for (int i = 0; i < N; i++) begin
            o.wen = 1'b1;
            o.addr = 15'(B1 + i);
            o.data = d[i*W +: W];
            opq.push_back(o);
        end
        for (int i = 0; i < N; i++) begin
            o.wen = 1'b0;
            o.addr = 15'(B1 + i);
            o.data = '0;
            opq.push_back(o);
            if (mask[i] && d[i*W +: W] != 8'hFF) e++;
        end
        r.t_done = cyc + 2*N + RL + 1;
        r.err = (AW+1)'(e);
        r.words = d;
        rq1.push_back(r);
        r.t_done = cyc + N + 1;
        r.err = '0;
        rq0.push_back(r);
        bad_mask = mask;
        data_in = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic pd1 = 1'b0;
    logic pd0 = 1'b0;
    logic ren0_seen = 1'b0;

    // Monitor: pops expectations whenever the DUTs present activity
    always @(negedge clk) begin
        if (!rst) begin
            op_t  o;
            res_t r;
            logic [N*W-1:0] got;
            if (ren0) ren0_seen = 1'b1;
            if (en1 && (wen1 || ren1)) begin
                if (opq.size() == 0) begin
                    chk("unexpected_op", {wen1, ren1, addr1}, 0);
                end else begin
                    o = opq.pop_front();
                    chk("op_kind", {wen1, ren1}, {o.wen, ~o.wen});
                    chk("op_addr", addr1, o.addr);
                    if (o.wen) chk("op_din", din1, o.data);
                    chk("op_busy", busy1, 1);
                end
            end
            if (done1 && !pd1) begin
                if (rq1.size() == 0) begin
                    chk("unexpected_done1", 1, 0);
                end else begin
                    r = rq1.pop_front();
                    chk("v1_latency", cyc, r.t_done);
                    chk("v1_err_count", errc1, r.err);
                    chk("v1_verify_err", verr1, r.err != 0);
                    chk("v1_busy_done", busy1, 0);
                end
            end
            if (done0 && !pd0) begin
                if (rq0.size() == 0) begin
                    chk("unexpected_done0", 1, 0);
                end else begin
                    r = rq0.pop_front();
                    for (int i = 0; i < N; i++) got[i*W +: W] = mem0[B0 + i];
                    chk("v0_latency", cyc, r.t_done);
                    chk("v0_bram", got, r.words);
                    chk("v0_err", {verr0, errc0}, 0);
                    chk("v0_no_ren", ren0_seen, 0);
                end
            end
        end
        pd1 <= done1;
        pd0 <= done0;
    end

    task automatic wait_done();
        int n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ctl1"}, {en1, wen1, ren1, busy1, done1, verr1}, 0);
        chk({nm, "_dat1"}, {addr1, din1, errc1}, 0);
        chk({nm, "_ctl0"}, {en0, wen0, ren0, busy0, done0, verr0}, 0);
    endtask

    initial begin
        logic [N*W-1:0] d;
        logic [W-1:0]   old [N];
        for (int i = 0; i < 32768; i++) begin
            mem1[i] = 8'($urandom);
            mem0[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // fixed pattern, clean read-back
        issue(64'h0706050403020100, 8'h00);
        wait_done();
        // back-to-back start from DONE, word 3 corrupted on read
        issue(64'h0706050403020100, 8'h08);
        wait_done();

        for (int t = 0; t < 12; t++) begin
            d = {$urandom, $urandom};
            if (t == 5) d[2*W +: W] = 8'hFF;
            issue(d, ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
            if (t % 3 == 1) begin
                repeat (2) @(negedge clk);
                data_in = {$urandom, $urandom};
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset after four words have been written
        d = {$urandom, $urandom};
        for (int i = 0; i < N; i++) old[i] = mem1[15'(B1 + i)];
        issue(d, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        opq.delete();
        rq1.delete();
        rq0.delete();
        #1;
        chk_idle_outputs("midreset");
        for (int i = 0; i < N; i++)
            chk("partial_bram", mem1[15'(B1 + i)], (i < 4) ? d[i*W +: W] : old[i]);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue({$urandom, $urandom}, 8'h81);
        wait_done();
        @(negedge clk);

        chk("ops_left", opq.size(), 0);
        chk("results_left", rq1.size() + rq0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
